// File: rtl/status_pkg.sv
// Shared flag indices, reset image and pending-update record for the ALU status stage.
// The update record carries a mask and value for each of N, V, Z and C.
package status_pkg;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_I = 2;
  localparam int FLAG_D = 3;
  localparam int FLAG_B = 4;
  localparam int FLAG_U = 5;
  localparam int FLAG_V = 6;
  localparam int FLAG_N = 7;

  localparam logic [7:0] RESET_P_DEFAULT = 8'h24;

  // Slot positions inside flag_upd_t.mask / flag_upd_t.val.
  localparam int UPD_C = 0;
  localparam int UPD_Z = 1;
  localparam int UPD_V = 2;
  localparam int UPD_N = 3;

  typedef struct packed {
    logic [3:0] mask;
    logic [3:0] val;
  } flag_upd_t;

  // Merge the masked N/V/Z/C values of an update into a status image.
  function automatic logic [7:0] apply_upd(input logic [7:0] p, input flag_upd_t u);
    logic [7:0] r;
    r = p;
    if (u.mask[UPD_C]) r[FLAG_C] = u.val[UPD_C];
    if (u.mask[UPD_Z]) r[FLAG_Z] = u.val[UPD_Z];
    if (u.mask[UPD_V]) r[FLAG_V] = u.val[UPD_V];
    if (u.mask[UPD_N]) r[FLAG_N] = u.val[UPD_N];
    return r;
  endfunction

endpackage

// File: rtl/flag_capture.sv
// Combinational N/V/Z/C generation and update mask for the pending flag buffer.
// In BIT mode N and V come from the data bus; Z always comes from the ALU result.
module flag_capture
  import status_pkg::*;
(
  input  logic [7:0] alu_out,
  input  logic       carry_out,
  input  logic       overflow,
  input  logic       db_n,
  input  logic       db_v,
  input  logic       load_add,
  input  logic       upd_c,
  input  logic       upd_v,
  input  logic       upd_nz,
  input  logic       bit_mode,
  output logic       capture,
  output flag_upd_t  upd
);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    upd = '0;
    upd.mask[UPD_C] = upd_c;
    upd.mask[UPD_V] = upd_v;
    upd.mask[UPD_Z] = upd_nz;
    upd.mask[UPD_N] = upd_nz;
    upd.val[UPD_C]  = carry_out;
    upd.val[UPD_V]  = bit_mode ? db_v : overflow;
    upd.val[UPD_Z]  = (alu_out == 8'h00);
    upd.val[UPD_N]  = bit_mode ? db_n : alu_out[7];
  end

  assign capture = load_add & (upd_c | upd_v | upd_nz);

endmodule

// File: rtl/alu_status_reg.sv
// ALU result hold register plus processor status register P with a one-entry pending flag buffer.
// Build option STATUS_BCD_EN: when defined, enable_dec_o follows D; otherwise it is tied 0.
module alu_status_reg
  import status_pkg::*;
#(
  parameter logic [7:0] RESET_P = RESET_P_DEFAULT
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] alu_out,
  input  logic       carry_out,
  input  logic       overflow,
  input  logic [7:0] db_in,
  input  logic       load_add,
  input  logic       upd_c,
  input  logic       upd_v,
  input  logic       upd_nz,
  input  logic       bit_mode,
  input  logic       load_p_db,
  input  logic       set_c,
  input  logic       clr_c,
  input  logic       set_i,
  input  logic       clr_i,
  input  logic       set_d,
  input  logic       clr_d,
  input  logic       clr_v,
  input  logic       brk_push,
  output logic [7:0] add_reg,
  output logic [7:0] p_flags,
  output logic [7:0] p_push,
  output logic       carry_in_o,
  output logic       enable_dec_o,
  output logic       pending
);

  // Bit5 is held at 1 and B at 0 in every stored image, including reset.
  localparam logic [7:0] P_RESET_IMG = (RESET_P | (8'h1 << FLAG_U)) & ~(8'h1 << FLAG_B);

  logic [7:0] add_q;
  logic [7:0] p_q;
  logic [7:0] p_d;
  logic       pend_valid_q;
  flag_upd_t  pend_q;
  logic       capture;
  flag_upd_t  upd_new;

  flag_capture u_flag_capture (
    .alu_out   (alu_out),
    .carry_out (carry_out),
    .overflow  (overflow),
    .db_n      (db_in[FLAG_N]),
    .db_v      (db_in[FLAG_V]),
    .load_add  (load_add),
    .upd_c     (upd_c),
    .upd_v     (upd_v),
    .upd_nz    (upd_nz),
    .bit_mode  (bit_mode),
    .capture   (capture),
    .upd       (upd_new)
  );

  // Later assignments win: pending commit, then direct ops (clear after set), then bus load.
  always_comb begin
    p_d = p_q;
    if (pend_valid_q) p_d = apply_upd(p_q, pend_q);
    if (set_c) p_d[FLAG_C] = 1'b1;
    if (clr_c) p_d[FLAG_C] = 1'b0;
    if (set_i) p_d[FLAG_I] = 1'b1;
    if (clr_i) p_d[FLAG_I] = 1'b0;
    if (set_d) p_d[FLAG_D] = 1'b1;
    if (clr_d) p_d[FLAG_D] = 1'b0;
    if (clr_v) p_d[FLAG_V] = 1'b0;
    if (load_p_db) p_d = db_in;
    p_d[FLAG_U] = 1'b1;
    p_d[FLAG_B] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the pending buffer contents are reset along with its valid bit so no stale update survives reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      add_q        <= 8'h00;
      p_q          <= P_RESET_IMG;
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
    end else begin
      if (load_add) add_q <= alu_out;
      p_q          <= p_d;
      pend_valid_q <= capture;
      pend_q       <= capture ? upd_new : '0;
    end
  end

  assign add_reg    = add_q;
  assign p_flags    = p_q;
  assign p_push     = p_q | ({7'b0, brk_push} << FLAG_B);
  assign carry_in_o = p_q[FLAG_C];
  assign pending    = pend_valid_q;

`ifdef STATUS_BCD_EN
  assign enable_dec_o = p_q[FLAG_D];
`else
  assign enable_dec_o = 1'b0;
`endif

endmodule

// File: tb/tb_alu_status_reg.sv
// Self-checking bench for alu_status_reg: directed vector table, async reset case,
// then randomized traffic against a queue-based flag model.
module tb_alu_status_reg;

  logic       clk = 1'b0;
  logic       nrst;
  logic [7:0] alu_out, db_in;
  logic       carry_out, overflow;
  logic       load_add, upd_c, upd_v, upd_nz, bit_mode, load_p_db;
  logic       set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v, brk_push;
  logic [7:0] add_reg, p_flags, p_push;
  logic       carry_in_o, enable_dec_o, pending;

  int n_checks = 0;
  int n_errors = 0;

  alu_status_reg dut (
    .clk(clk), .nrst(nrst), .alu_out(alu_out), .carry_out(carry_out), .overflow(overflow),
    .db_in(db_in), .load_add(load_add), .upd_c(upd_c), .upd_v(upd_v), .upd_nz(upd_nz),
    .bit_mode(bit_mode), .load_p_db(load_p_db), .set_c(set_c), .clr_c(clr_c),
    .set_i(set_i), .clr_i(clr_i), .set_d(set_d), .clr_d(clr_d), .clr_v(clr_v),
    .brk_push(brk_push), .add_reg(add_reg), .p_flags(p_flags), .p_push(p_push),
    .carry_in_o(carry_in_o), .enable_dec_o(enable_dec_o), .pending(pending)
  );

  always #5 clk = ~clk;

  localparam logic [12:0] NONE = 13'h0000;
  localparam logic [12:0] LA   = 13'h0001;
  localparam logic [12:0] UC   = 13'h0002;
  localparam logic [12:0] UV   = 13'h0004;
  localparam logic [12:0] UNZ  = 13'h0008;
  localparam logic [12:0] BITM = 13'h0010;
  localparam logic [12:0] LDB  = 13'h0020;
  localparam logic [12:0] SC   = 13'h0040;
  localparam logic [12:0] CC   = 13'h0080;
  localparam logic [12:0] SI   = 13'h0100;
  localparam logic [12:0] CI   = 13'h0200;
  localparam logic [12:0] SD   = 13'h0400;
  localparam logic [12:0] CD   = 13'h0800;
  localparam logic [12:0] CV   = 13'h1000;

  typedef struct {
    logic [7:0]  alu;
    logic        co;
    logic        ov;
    logic [7:0]  db;
    logic [12:0] ctrl;
    logic [7:0]  exp_add;
    logic [7:0]  exp_p;
    logic        exp_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [7:0] alu, logic co, logic ov, logic [7:0] db,
                              logic [12:0] ctrl, logic [7:0] ea, logic [7:0] ep, logic epend);
    vec_t v;
    v.alu = alu; v.co = co; v.ov = ov; v.db = db; v.ctrl = ctrl;
    v.exp_add = ea; v.exp_p = ep; v.exp_pend = epend;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [7:0] alu, input logic co, input logic ov,
                       input logic [7:0] db, input logic [12:0] ctrl, input logic brk);
    alu_out = alu; carry_out = co; overflow = ov; db_in = db;
    load_add = ctrl[0];  upd_c = ctrl[1]; upd_v = ctrl[2];  upd_nz = ctrl[3];
    bit_mode = ctrl[4];  load_p_db = ctrl[5];
    set_c = ctrl[6]; clr_c = ctrl[7]; set_i = ctrl[8]; clr_i = ctrl[9];
    set_d = ctrl[10]; clr_d = ctrl[11]; clr_v = ctrl[12];
    brk_push = brk;
  endtask

  function automatic logic exp_dec(input logic [7:0] p);
`ifdef STATUS_BCD_EN
    return p[3];
`else
    return 1'b0;
`endif
  endfunction

  // Behavioural model: individual flag bits, result byte and a queue of not-yet-committed updates.
  typedef struct {
    bit has_nz, has_v, has_c;
    bit n, v, z, c;
  } entry_t;

  entry_t  m_q[$];
  bit      m_n, m_v, m_d, m_i, m_z, m_c;
  bit [7:0] m_add;

  function automatic logic [7:0] model_p();
    return {m_n, m_v, 1'b1, 1'b0, m_d, m_i, m_z, m_c};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_add = 8'h00;
    {m_n, m_v, m_d, m_i, m_z, m_c} = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  endtask

  task automatic model_step(input logic [7:0] alu, input logic co, input logic ov,
                            input logic [7:0] db, input logic [12:0] c);
    entry_t e;
    if (m_q.size() > 0) begin
      e = m_q.pop_front();
      if (c[5] == 1'b0) begin
        if (e.has_nz) begin m_n = e.n; m_z = e.z; end
        if (e.has_v)  m_v = e.v;
        if (e.has_c)  m_c = e.c;
      end
    end
    if (c[6])  m_c = 1; if (c[7])  m_c = 0;
    if (c[8])  m_i = 1; if (c[9])  m_i = 0;
    if (c[10]) m_d = 1; if (c[11]) m_d = 0;
    if (c[12]) m_v = 0;
    if (c[5]) {m_n, m_v, m_d, m_i, m_z, m_c} = {db[7], db[6], db[3], db[2], db[1], db[0]};
    if (c[0]) begin
      m_add = alu;
      if (c[1] || c[2] || c[3]) begin
        e.has_c = c[1]; e.has_v = c[2]; e.has_nz = c[3];
        e.c = co;
        e.v = c[4] ? db[6] : ov;
        e.n = c[4] ? db[7] : alu[7];
        e.z = (alu == 8'h00);
        m_q.push_back(e);
      end
    end
  endtask

  initial begin
    nrst = 1'b0;
    drive(8'h00, 1'b0, 1'b0, 8'h00, NONE, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_add", add_reg, 8'h00);
    check("reset_p", p_flags, 8'h24);
    check("reset_pend", {7'b0, pending}, 8'h00);
    check("reset_dec", {7'b0, enable_dec_o}, 8'h00);
    check("reset_cin", {7'b0, carry_in_o}, 8'h00);
    @(negedge clk);
    nrst = 1'b1;

    //          alu   co    ov    db     ctrl            add    p      pend
    vecs.push_back(mk(8'h00, 1'b1, 1'b0, 8'h00, LA|UC|UNZ,      8'h00, 8'h24, 1'b1));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 8'h00, NONE,           8'h00, 8'h27, 1'b0));
    vecs.push_back(mk(8'h80, 1'b0, 1'b0, 8'h00, LA|UNZ,         8'h80, 8'h27, 1'b1));
    vecs.push_back(mk(8'h01, 1'b0, 1'b0, 8'h00, LA|UNZ,         8'h01, 8'hA5, 1'b1));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 8'h00, NONE,           8'h01, 8'h25, 1'b0));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 8'h00, CC,             8'h01, 8'h24, 1'b0));
    vecs.push_back(mk(8'h05, 1'b1, 1'b0, 8'h00, LA|UC,          8'h05, 8'h24, 1'b1));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 8'h00, CC,             8'h05, 8'h24, 1'b0));
    vecs.push_back(mk(8'h80, 1'b0, 1'b0, 8'h00, LA|UC|UNZ,      8'h80, 8'h24, 1'b1));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 8'hC3, LDB,            8'h80, 8'hE3, 1'b0));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 8'h00, NONE,           8'h80, 8'hE3, 1'b0));
    vecs.push_back(mk(8'h11, 1'b1, 1'b0, 8'h00, LDB|LA|UC,      8'h11, 8'h20, 1'b1));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 8'h00, NONE,           8'h11, 8'h21, 1'b0));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 8'hC0, LA|UNZ|UV|BITM, 8'h00, 8'h21, 1'b1));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 8'h00, NONE,           8'h00, 8'hE3, 1'b0));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 8'h00, SD,             8'h00, 8'hEB, 1'b0));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 8'h00, SI,             8'h00, 8'hEF, 1'b0));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 8'h00, SI|CI,          8'h00, 8'hEB, 1'b0));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 8'h00, SC|CC,          8'h00, 8'hEA, 1'b0));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 8'h00, CV,             8'h00, 8'hAA, 1'b0));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 8'h00, CD,             8'h00, 8'hA2, 1'b0));
    vecs.push_back(mk(8'h00, 1'b1, 1'b0, 8'h00, UC|UNZ,         8'h00, 8'hA2, 1'b0));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 8'h00, LA|UC,          8'h00, 8'hA2, 1'b1));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 8'h00, SC,             8'h00, 8'hA3, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].alu, vecs[i].co, vecs[i].ov, vecs[i].db, vecs[i].ctrl, 1'b0);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_add", i), add_reg, vecs[i].exp_add);
      check($sformatf("vec%0d_p", i), p_flags, vecs[i].exp_p);
      check($sformatf("vec%0d_pend", i), {7'b0, pending}, {7'b0, vecs[i].exp_pend});
      check($sformatf("vec%0d_cin", i), {7'b0, carry_in_o}, {7'b0, vecs[i].exp_p[0]});
      check($sformatf("vec%0d_dec", i), {7'b0, enable_dec_o}, {7'b0, exp_dec(vecs[i].exp_p)});
    end

    // Asynchronous reset while an update is pending, then confirm the buffer was flushed.
    drive(8'hFF, 1'b1, 1'b1, 8'h00, LA|UC|UV|UNZ|SD, 1'b0);
    @(posedge clk);
    #1;
    check("mid_pend", {7'b0, pending}, 8'h01);
    drive(8'h00, 1'b0, 1'b0, 8'h00, NONE, 1'b0);
    #2 nrst = 1'b0;
    #1;
    check("mid_rst_add", add_reg, 8'h00);
    check("mid_rst_p", p_flags, 8'h24);
    check("mid_rst_pend", {7'b0, pending}, 8'h00);
    check("mid_rst_dec", {7'b0, enable_dec_o}, 8'h00);
    #2 nrst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_p", p_flags, 8'h24);
    check("post_rst_pend", {7'b0, pending}, 8'h00);

    // Randomized traffic against the model, starting from the reset state above.
    model_reset();
    for (int k = 0; k < 600; k++) begin
      logic [12:0] c;
      logic [7:0]  a, d;
      logic        co, ov, brk;
      c = NONE;
      if ($urandom_range(0, 2) != 0) c |= LA;
      if ($urandom_range(0, 1) != 0) c |= UC;
      if ($urandom_range(0, 1) != 0) c |= UV;
      if ($urandom_range(0, 1) != 0) c |= UNZ;
      if ($urandom_range(0, 3) == 0) c |= BITM;
      if ($urandom_range(0, 9) == 0) c |= LDB;
      if ($urandom_range(0, 7) == 0) c |= SC;
      if ($urandom_range(0, 7) == 0) c |= CC;
      if ($urandom_range(0, 7) == 0) c |= SI;
      if ($urandom_range(0, 7) == 0) c |= CI;
      if ($urandom_range(0, 7) == 0) c |= SD;
      if ($urandom_range(0, 7) == 0) c |= CD;
      if ($urandom_range(0, 7) == 0) c |= CV;
      a   = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      d   = 8'($urandom);
      co  = 1'($urandom);
      ov  = 1'($urandom);
      brk = 1'($urandom);
      drive(a, co, ov, d, c, brk);
      model_step(a, co, ov, d, c);
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d_add", k), add_reg, m_add);
      check($sformatf("rnd%0d_p", k), p_flags, model_p());
      check($sformatf("rnd%0d_push", k), p_push, model_p() | {3'b0, brk, 4'b0});
      check($sformatf("rnd%0d_pend", k), {7'b0, pending}, {7'b0, m_q.size() != 0});
      check($sformatf("rnd%0d_cin", k), {7'b0, carry_in_o}, {7'b0, m_c});
      check($sformatf("rnd%0d_dec", k), {7'b0, enable_dec_o}, {7'b0, exp_dec(model_p())});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_status_reg.md
# alu_status_reg

Status and result stage downstream of the ALU. It latches the ALU result into the adder hold register. It captures carry, overflow, zero and negative into a one-entry pending-flag buffer and commits them to the processor status register P one cycle later. It also feeds `carry_in` and `enable_dec` back to the ALU, and provides the P image for stack pushes.

## Interface
- `RESET_P`, default 8'h24, status image loaded at reset (I=1, bit5=1).

Ports:
- `clk` in 1: system clock.
- `nrst` in 1: asynchronous, active-low reset.
- `alu_out` in 8: ALU result.
- `carry_out` in 1: ALU carry.
- `overflow` in 1: ALU overflow.
- `db_in` in 8: data bus, used for PLP/RTI and BIT.
- `load_add` in 1: latch `alu_out` into the hold register.
- `upd_c`, `upd_v`, `upd_nz` in 1 each: flag groups to capture with `load_add`.
- `bit_mode` in 1: with `upd_nz`/`upd_v`, N=db_in[7], V=db_in[6], Z from `alu_out`.
- `load_p_db` in 1: P <= db_in (bit5 forced 1, B ignored).
- `set_c`, `clr_c`, `set_i`, `clr_i`, `set_d`, `clr_d`, `clr_v` in 1 each: direct flag operations.
- `brk_push` in 1: B bit value reported in `p_push`.
- `add_reg` out 8: adder hold register.
- `p_flags` out 8: committed {N,V,1,0,D,I,Z,C}.
- `p_push` out 8: {N,V,1,brk_push,D,I,Z,C}.
- `carry_in_o` out 1: committed C, to the ALU.
- `enable_dec_o` out 1: committed D, to the ALU.
- `pending` out 1: a flag update is queued but not yet committed.

## Operation
- Hold register: on a rising edge with `load_add`=1, add_reg <= alu_out. Otherwise it holds its value.
- Capture: on a rising edge with `load_add`=1 and any `upd_*` set, the pending buffer stores a mask plus values:
  - C = carry_out
  - V = overflow, or db_in[6] if `bit_mode`
  - Z = (alu_out==0)
  - N = alu_out[7], or db_in[7] if `bit_mode`
  - `pending` <= 1.
- Commit: at the edge after capture, masked bits are written into P and `pending` <= 0. This is a fixed one-cycle latency.
- Back-to-back captures: the edge that captures entry k+1 also commits entry k. No update is lost, and `pending` stays 1.
- Priority within one edge, highest first:
  1. `load_p_db`: overwrites all of P and discards any pending entry. A same-edge capture is still accepted.
  2. Direct set/clr ops on their own bits.
  3. Pending commit.
- Direct ops:
  - `set_x` together with `clr_x` on the same edge: clear wins.
  - Direct ops act on the same edge they are asserted (zero latency).
- Outputs:
  - `p_flags`, `carry_in_o` and `enable_dec_o` reflect committed P only. Pending values are never visible on them.
  - Bit5 always reads 1.
  - B always reads 0 in `p_flags`.

## Timing
- Reset (`nrst`=0, asynchronous, mid-operation included):
  - add_reg=0, P=RESET_P, pending=0, the pending buffer is cleared.
  - Outputs: p_flags=8'h24, carry_in_o=0, enable_dec_o=0.
- Result latency: `load_add` at edge t gives `add_reg` valid after t.
- Flag latency:
  - Captured at edge t, committed at edge t+1.
  - Visible on `p_flags` after t+1.
  - If `load_p_db` is asserted at t+1, the pending entry is dropped.
- `upd_*` without `load_add` is ignored.
- All outputs are registered except `p_push`, which is combinational from P and `brk_push`.

## Configuration
- `STATUS_BCD_EN` defined:
  - D is writable via `set_d`, `clr_d` and `load_p_db`.
  - `enable_dec_o` = D.
- `STATUS_BCD_EN` undefined (binary-only part):
  - D storage is still present and readable in `p_flags` and `p_push`.
  - `enable_dec_o` is tied 0.

## Structure
- Package `status_pkg`:
  - Bit index constants FLAG_C=0, FLAG_Z=1, FLAG_I=2, FLAG_D=3, FLAG_B=4, FLAG_U=5, FLAG_V=6, FLAG_N=7.
  - Default `RESET_P`.
  - Packed typedef `flag_upd_t` {mask[3:0], val[3:0]} for N, V, Z, C.
- One sub-module, `flag_capture`: combinational N/V/Z/C generation plus the mask, feeding the pending register.

## Test plan
- Reset: assert `nrst`=0 mid-capture → add_reg=0, p_flags=8'h24, pending=0, enable_dec_o=0.
- Capture and commit: alu_out=8'h00, carry_out=1, `load_add` with upd_c/upd_nz → add_reg=0 next cycle; p_flags=8'h27 one cycle later (Z=1, C=1).
- Back-to-back captures:
  - alu_out=8'h80 (N=1) then 8'h01 (N=0, Z=0) on consecutive edges.
  - Required: N=1 seen for exactly one cycle, then p_flags[7]=0, pending=0 after the final commit.
- Collision:
  - Pending C=1 commit on the same edge as `clr_c` → C=0.
  - `load_p_db` with db_in=8'hC3 on the commit edge → p_flags=8'hE3 and the pending entry is discarded.
- BIT: db_in=8'hC0, alu_out=8'h00, bit_mode with upd_nz/upd_v → N=1, V=1, Z=1 committed.
- BCD option: `set_d` → enable_dec_o=1 with `STATUS_BCD_EN`, and 0 without it; p_flags[3]=1 in both builds.
